// File: rtl/ntt8_stage_scheduler_if.sv
// Control/handshake bundle between the NTT stage scheduler and its environment.
// master = scheduler side, slave = top-level control plus twiddle/butterfly datapath.
interface ntt8_stage_scheduler_if;
    logic       go;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] tw_i;
    logic [4:0] tw_j;
    logic [4:0] tw_N;
    logic       tw_start;
    logic       tw_ack;
    logic       buf_ack;
    logic [2:0] rd_addr_u;
    logic [2:0] rd_addr_v;
    logic       wr_en;
    logic [2:0] wr_addr_u;
    logic [2:0] wr_addr_v;
    logic [1:0] stage;
    logic [1:0] bfly;

    modport master (
        input  go, tw_ack, buf_ack,
        output busy, done, err, tw_i, tw_j, tw_N, tw_start,
               rd_addr_u, rd_addr_v, wr_en, wr_addr_u, wr_addr_v, stage, bfly
    );

    modport slave (
        output go, tw_ack, buf_ack,
        input  busy, done, err, tw_i, tw_j, tw_N, tw_start,
               rd_addr_u, rd_addr_v, wr_en, wr_addr_u, wr_addr_v, stage, bfly
    );
endinterface

// File: rtl/ntt8_stage_scheduler.sv
// Walks 3 stages x 4 butterflies of an in-place DIT 8-point NTT, min 4 cycles per butterfly.
// Waits on level acks from twiddle/butterfly units; a per-wait watchdog aborts with sticky err.
module ntt8_stage_scheduler #(
    parameter int NPTS    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    ntt8_stage_scheduler_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TW, WAIT_BUF, WRITE, DONE} state_t;

    state_t        state_q;
    logic [1:0]    s_q, k_q, pos_q;
    logic [2:0]    u_q, v_q;
    logic [CW-1:0] wdog_q;
    logic          busy_q, done_q, err_q, tw_start_q, wr_en_q;

    logic [1:0]    s_d, k_d, pos_d;
    logic [2:0]    u_d, v_d;
    logic [2:0]    half_w, grp_w;
    logic          last_d;

    // Coordinates and addresses of the butterfly to load next (first one when leaving IDLE).
    always_comb begin
        last_d = (k_q == 2'd3) && (s_q == 2'd2);
        s_d    = s_q;
        k_d    = k_q + 2'd1;
        if (state_q == IDLE) begin
            s_d = 2'd0;
            k_d = 2'd0;
        end else if (k_q == 2'd3) begin
            s_d = s_q + 2'd1;
            k_d = 2'd0;
        end
        half_w = 3'd1 << s_d;
        grp_w  = {1'b0, k_d} >> s_d;
        pos_d  = k_d & half_w[1:0] - 2'd1;
        u_d    = (grp_w << (s_d + 2'd1)) | {1'b0, pos_d};
        v_d    = u_d + half_w;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            s_q        <= 2'd0;
            k_q        <= 2'd0;
            pos_q      <= 2'd0;
            u_q        <= 3'd0;
            v_q        <= 3'd0;
            wdog_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tw_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            tw_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.go) begin
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        s_q        <= s_d;
                        k_q        <= k_d;
                        pos_q      <= pos_d;
                        u_q        <= u_d;
                        v_q        <= v_d;
                        tw_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= WAIT_TW;
                end
                WAIT_TW: begin
                    if (bus.tw_ack) begin
                        wdog_q  <= '0;
                        state_q <= WAIT_BUF;
                    end else if (wdog_q == CW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + CW'(1);
                    end
                end
                WAIT_BUF: begin
                    if (bus.buf_ack) begin
                        wr_en_q <= 1'b1;
                        state_q <= WRITE;
                    end else if (wdog_q == CW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + CW'(1);
                    end
                end
                WRITE: begin
                    if (last_d) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        s_q        <= s_d;
                        k_q        <= k_d;
                        pos_q      <= pos_d;
                        u_q        <= u_d;
                        v_q        <= v_d;
                        tw_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.tw_i      = {3'b000, s_q};
    assign bus.tw_j      = {3'b000, pos_q};
    assign bus.tw_N      = 5'(NPTS);
    assign bus.tw_start  = tw_start_q;
    assign bus.rd_addr_u = u_q;
    assign bus.rd_addr_v = v_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr_u = u_q;
    assign bus.wr_addr_v = v_q;
    assign bus.stage     = s_q;
    assign bus.bfly      = k_q;
endmodule

// File: tb/tb_ntt8_stage_scheduler.sv
// Scoreboarded bench for the 8-point NTT stage scheduler: expected butterfly order is queued
// at go and checked against every tw_start/wr_en the scheduler emits.
module tb_ntt8_stage_scheduler;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ntt8_stage_scheduler_if bus();

    ntt8_stage_scheduler #(.NPTS(8), .TIMEOUT(TIMEOUT)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int s;
        int k;
        int u;
        int v;
        int j;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    int exp_u[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_v[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_j[12] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 2, 3};

    // Runs one transform: twd/bfd are ack delays (cycles after the ISSUE cycle), butterfly tgt
    // uses tw delay tgt_d instead, rst_tgt asserts reset in that butterfly's WAIT_BUF.
    task automatic run(input int twd, input int bfd, input int tgt, input int tgt_d,
                       input int rst_tgt, input bit stray, input int budget,
                       output int done_n, output int err_n, output int n_wr,
                       output int n_tws, output int busy_bad, output int tgt_issue_n);
        int   n, c, idx, eff;
        bit   armed, started, unstable;
        exp_t cur;
        done_n = 0; err_n = 0; n_wr = 0; n_tws = 0; busy_bad = 0; tgt_issue_n = 0;
        n = 0; c = 0; idx = -1; armed = 0; started = 0; unstable = 0;
        cur = '{0, 0, 0, 0, 0};
        for (int b = 0; b < 12; b++)
            sb.push_back('{b / 4, b % 4, exp_u[b], exp_v[b], exp_j[b]});
        bus.go = 1'b1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (started && !bus.done && !bus.err && bus.busy !== 1'b1) busy_bad++;
            if (bus.tw_start === 1'b1) begin
                started = 1; n_tws++; idx++; c = 0; armed = 1; unstable = 0;
                if (idx == tgt) tgt_issue_n = n;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL issue_extra: tw_start #%0d with empty scoreboard", n_tws);
                end else begin
                    cur = sb.pop_front();
                    if (bus.stage !== 2'(cur.s) || bus.bfly !== 2'(cur.k) ||
                        bus.rd_addr_u !== 3'(cur.u) || bus.rd_addr_v !== 3'(cur.v) ||
                        bus.tw_i !== 5'(cur.s) || bus.tw_j !== 5'(cur.j) || bus.tw_N !== 5'd8) begin
                        bad++;
                        $display("FAIL issue b=%0d: got s=%0d k=%0d u=%0d v=%0d i=%0d j=%0d N=%0d want s=%0d k=%0d u=%0d v=%0d j=%0d N=8",
                                 idx, bus.stage, bus.bfly, bus.rd_addr_u, bus.rd_addr_v,
                                 bus.tw_i, bus.tw_j, bus.tw_N, cur.s, cur.k, cur.u, cur.v, cur.j);
                    end
                end
            end else if (armed) begin
                c++;
                if (bus.rd_addr_u !== 3'(cur.u) || bus.rd_addr_v !== 3'(cur.v) ||
                    bus.stage !== 2'(cur.s) || bus.bfly !== 2'(cur.k) || bus.tw_j !== 5'(cur.j))
                    unstable = 1;
            end
            if (bus.wr_en === 1'b1) begin
                n_wr++;
                total++;
                if (bus.wr_addr_u !== 3'(cur.u) || bus.wr_addr_v !== 3'(cur.v) || unstable) begin
                    bad++;
                    $display("FAIL write b=%0d: got wu=%0d wv=%0d unstable=%0d want wu=%0d wv=%0d unstable=0",
                             idx, bus.wr_addr_u, bus.wr_addr_v, unstable, cur.u, cur.v);
                end
                armed = 0;
            end
            if (bus.done === 1'b1) begin done_n = n; break; end
            if (bus.err === 1'b1) begin err_n = n; break; end
            bus.go = (started && stray && (n == 10 || n == 30)) ? 1'b1 : (started ? 1'b0 : 1'b1);
            eff = (idx == tgt) ? tgt_d : twd;
            bus.tw_ack  = armed && (c >= eff);
            bus.buf_ack = armed && ((c >= eff + bfd) || (stray && c == 1));
            if (armed && idx == rst_tgt && c == twd + bfd) begin
                reset = 1'b1;
                break;
            end
        end
        bus.go = 1'b0;
        bus.tw_ack = 1'b0;
        bus.buf_ack = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.err, bus.tw_start, bus.wr_en, bus.tw_i, bus.tw_j,
             bus.rd_addr_u, bus.rd_addr_v, bus.wr_addr_u, bus.wr_addr_v, bus.stage, bus.bfly} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b tws=%b wr=%b u=%0d v=%0d s=%0d k=%0d want all 0",
                     bus.busy, bus.done, bus.err, bus.tw_start, bus.wr_en,
                     bus.rd_addr_u, bus.rd_addr_v, bus.stage, bus.bfly);
        end
        total++;
        if (bus.tw_N !== 5'd8) begin
            bad++;
            $display("FAIL reset_twN: got %0d want 8", bus.tw_N);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_run(input string name, input int done_n, input int err_n, input int n_wr,
                             input int n_tws, input int busy_bad, input int want_done);
        total++;
        if (done_n != want_done || err_n != 0 || n_wr != 12 || n_tws != 12 || busy_bad != 0 || sb.size() != 0) begin
            bad++;
            $display("FAIL %s: done@%0d err@%0d wr=%0d tws=%0d busy_bad=%0d left=%0d want done@%0d err@0 wr=12 tws=12 busy_bad=0 left=0",
                     name, done_n, err_n, n_wr, n_tws, busy_bad, sb.size(), want_done);
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_tied_acks;
        int d, e, w, t, b, ti;
        run(0, 0, -1, 0, -1, 0, 200, d, e, w, t, b, ti);
        check_run("tied_acks", d, e, w, t, b, 49);
    endtask

    task automatic test_delayed_acks;
        int d, e, w, t, b, ti;
        run(5, 3, -1, 0, -1, 0, 300, d, e, w, t, b, ti);
        check_run("delayed_acks", d, e, w, t, b, 121);
    endtask

    task automatic test_timeout;
        int d, e, w, t, b, ti;
        run(0, 0, 6, NEVER, -1, 0, 300, d, e, w, t, b, ti);
        total++;
        if (e == 0 || e - ti != TIMEOUT + 1 || d != 0 || w != 6 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout: err@%0d issue@%0d delta=%0d done@%0d wr=%0d busy=%b want delta=%0d done@0 wr=6 busy=0",
                     e, ti, e - ti, d, w, bus.busy, TIMEOUT + 1);
        end
        sb.delete();
        repeat (3) @(negedge clk);
        total++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL err_sticky: err=%b busy=%b done=%b want err=1 busy=0 done=0", bus.err, bus.busy, bus.done);
        end
        run(0, 0, -1, 0, -1, 0, 200, d, e, w, t, b, ti);
        check_run("recover_after_err", d, e, w, t, b, 49);
    endtask

    task automatic test_ack_at_timeout;
        int d, e, w, t, b, ti;
        run(0, 0, 6, TIMEOUT, -1, 0, 300, d, e, w, t, b, ti);
        check_run("ack_wins_timeout", d, e, w, t, b, 49 + TIMEOUT - 1);
    endtask

    task automatic test_reset_midrun;
        int d, e, w, t, b, ti;
        run(0, 3, -1, 0, 8, 0, 300, d, e, w, t, b, ti);
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.err, bus.tw_start, bus.wr_en, bus.tw_i, bus.tw_j,
             bus.rd_addr_u, bus.rd_addr_v, bus.stage, bus.bfly} !== '0 || bus.tw_N !== 5'd8 || w != 8 || d != 0) begin
            bad++;
            $display("FAIL reset_midrun: busy=%b done=%b wr_en=%b u=%0d v=%0d s=%0d k=%0d N=%0d writes=%0d want zeros N=8 writes=8",
                     bus.busy, bus.done, bus.wr_en, bus.rd_addr_u, bus.rd_addr_v,
                     bus.stage, bus.bfly, bus.tw_N, w);
        end
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        run(0, 0, -1, 0, -1, 0, 200, d, e, w, t, b, ti);
        check_run("restart_after_reset", d, e, w, t, b, 49);
    endtask

    task automatic test_stray_inputs;
        int d, e, w, t, b, ti;
        run(3, 2, -1, 0, -1, 1, 300, d, e, w, t, b, ti);
        check_run("stray_go_buf", d, e, w, t, b, 85);
    endtask

    task automatic test_back_to_back;
        int d, e, w, t, b, ti;
        run(0, 0, -1, 0, -1, 0, 200, d, e, w, t, b, ti);
        total++;
        if (d != 49) begin
            bad++;
            $display("FAIL b2b_first: done@%0d want 49", d);
        end
        sb.delete();
        run(0, 0, -1, 0, -1, 0, 200, d, e, w, t, b, ti);
        check_run("b2b_second", d, e, w, t, b, 50);
    endtask

    initial begin
        bus.go = 1'b0;
        bus.tw_ack = 1'b0;
        bus.buf_ack = 1'b0;
        @(negedge clk);
        test_reset;
        test_tied_acks;
        test_delayed_acks;
        test_timeout;
        test_ack_at_timeout;
        test_reset_midrun;
        test_stray_inputs;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
